// File: rtl/vga_frame_monitor_if.sv
// VGA pin bundle seen by the frame monitor: syncs plus 4:4:4 colour.
// Pure wiring, no latency; the monitor only listens and never drives these pins.
// No backpressure: the source owns every signal, the sink samples them.
interface vga_frame_monitor_if;
  logic       hsync;
  logic       vsync;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  modport master (output hsync, output vsync, output vga_r, output vga_g, output vga_b);
  modport slave  (input  hsync, input  vsync, input  vga_r, input  vga_g, input  vga_b);
endinterface

// File: rtl/vga_frame_monitor.sv
// VGA receive-side checker: recovers x/y, checks line/frame timing, locks, captures a probe pixel.
// Latency: inputs registered once, edges seen one cycle later; status pulses are registered (+1 cycle).
// No backpressure: pure sink, every input sample is consumed every clock.
module vga_frame_monitor #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_ACTIVE       = 640,
  parameter int H_TOTAL        = 800,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 525,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_monitor_if.slave  vga,
  input  logic [9:0]          probe_x,
  input  logic [9:0]          probe_y,
  output logic                locked,
  output logic [15:0]         frame_count,
  output logic [7:0]          err_count,
  output logic                timing_err,
  output logic                blank_err,
  output logic                probe_valid,
  output logic [11:0]         probe_rgb
);

  localparam int PH_W = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_PIXEL - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLKS_PER_PIXEL / 2);
  localparam logic [11:0]     LINE_CLKS = 12'(H_TOTAL * CLKS_PER_PIXEL - 1);
  localparam logic [11:0]     SYNC_CLKS = 12'(H_SYNC * CLKS_PER_PIXEL);
  localparam logic [10:0]     FRAME_LINES = 11'(V_TOTAL);
  localparam logic [9:0]      VSYNC_LINES = 10'(V_SYNC);
  localparam logic [9:0]      X_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]      X_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]      Y_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]      Y_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [7:0]      LOCK_GOOD = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  // Input sampling: stage 1 is the working copy, stage 2 only serves edge detection.
  logic        hs1_q, hs1_d, hs2_q, hs2_d;
  logic        vs1_q, vs1_d, vs2_q, vs2_d;
  logic [11:0] rgb1_q, rgb1_d;

  // Timing measurement counters.
  logic [11:0]     line_clks_q, line_clks_d;
  logic [11:0]     low_clks_q, low_clks_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [9:0]      pix_cnt_q, pix_cnt_d;
  logic [9:0]      v_line_q, v_line_d;
  logic [9:0]      vs_lines_q, vs_lines_d;

  // Lock tracking.
  state_e      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        frame_bad_q, frame_bad_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;

  // Registered pulse / capture outputs.
  logic        timing_err_q, timing_err_d;
  logic        blank_err_q, blank_err_d;
  logic        probe_valid_q, probe_valid_d;
  logic [11:0] probe_rgb_q, probe_rgb_d;

  // Combinational events.
  logic        hs_edge, hs_rise, vs_edge, vs_rise;
  logic [10:0] lines_at_vs;
  logic        line_err, frame_err, err_any;
  logic        tracking, strobe, in_active;
  logic [9:0]  pix_x, pix_y;
  logic        blank_hit, probe_hit, good_frame;

  // Sync edges: falling edge is the sync assertion, rising edge ends the pulse.
  assign hs_edge = hs2_q & ~hs1_q;
  assign hs_rise = ~hs2_q & hs1_q;
  assign vs_edge = vs2_q & ~vs1_q;
  assign vs_rise = ~vs2_q & vs1_q;

  // Position is meaningless until a vsync edge has aligned v_line, so decode only after that.
  assign tracking = (state_q != ST_UNLOCKED);

  // Sample pipeline and line/frame timing counters with their error checks.
  always_comb begin
    hs1_d  = vga.hsync;
    hs2_d  = hs1_q;
    vs1_d  = vga.vsync;
    vs2_d  = vs1_q;
    rgb1_d = {vga.vga_r, vga.vga_g, vga.vga_b};

    line_clks_d = line_clks_q;
    low_clks_d  = low_clks_q;
    phase_d     = phase_q;
    pix_cnt_d   = pix_cnt_q;
    v_line_d    = v_line_q;
    vs_lines_d  = vs_lines_q;

    if (hs_edge)                      line_clks_d = 12'd0;
    else if (line_clks_q != 12'hFFF)  line_clks_d = line_clks_q + 12'd1;

    if (hs_edge)                             low_clks_d = 12'd1;
    else if (!hs1_q && low_clks_q != 12'hFFF) low_clks_d = low_clks_q + 12'd1;

    if (hs_edge || phase_q == PH_LAST) phase_d = '0;
    else                               phase_d = phase_q + PH_W'(1);

    if (hs_edge)                                         pix_cnt_d = 10'd0;
    else if (phase_q == PH_LAST && pix_cnt_q != 10'h3FF) pix_cnt_d = pix_cnt_q + 10'd1;

    // A coincident hsync edge belongs to the frame being closed, then v_line restarts at 0.
    lines_at_vs = {1'b0, v_line_q} + {10'd0, hs_edge};
    if (vs_edge)                           v_line_d = 10'd0;
    else if (hs_edge && v_line_q != 10'h3FF) v_line_d = v_line_q + 10'd1;

    if (vs_edge)                                       vs_lines_d = {9'd0, hs_edge};
    else if (hs_edge && !vs1_q && vs_lines_q != 10'h3FF) vs_lines_d = vs_lines_q + 10'd1;

    line_err  = (hs_edge && line_clks_q != LINE_CLKS) ||
                (hs_rise && low_clks_q != SYNC_CLKS);
    frame_err = (vs_edge && lines_at_vs != FRAME_LINES) ||
                (vs_rise && vs_lines_q != VSYNC_LINES);
    err_any   = tracking && (line_err || frame_err);
  end

  // Pixel decode: blanking violations and probe capture at the mid-pixel strobe.
  always_comb begin
    strobe    = (phase_q == PH_SAMPLE);
    in_active = (pix_cnt_q >= X_START) && (pix_cnt_q < X_END) &&
                (v_line_q >= Y_START) && (v_line_q < Y_END);
    pix_x     = pix_cnt_q - X_START;
    pix_y     = v_line_q - Y_START;
    blank_hit = tracking && strobe && !in_active && (rgb1_q != 12'd0);
    probe_hit = tracking && strobe && in_active && (pix_x == probe_x) && (pix_y == probe_y);

    blank_err_d   = blank_hit;
    probe_valid_d = probe_hit;
    probe_rgb_d   = probe_hit ? rgb1_q : probe_rgb_q;
  end

  // Lock FSM next state, good-frame counting and error accounting.
  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    frame_count_d = frame_count_q;
    frame_bad_d   = vs_edge ? 1'b0 : (frame_bad_q | err_any);
    good_frame    = vs_edge && !err_any && !frame_bad_q;
    timing_err_d  = err_any;
    err_count_d   = (err_any && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;

    case (state_q)
      ST_UNLOCKED: begin
        if (vs_edge) begin
          state_d = ST_ACQUIRE;
          good_d  = 8'd0;
        end
      end
      ST_ACQUIRE: begin
        if (err_any) begin
          good_d = 8'd0;
        end else if (good_frame) begin
          good_d        = good_q + 8'd1;
          frame_count_d = frame_count_q + 16'd1;
          if (good_q + 8'd1 == LOCK_GOOD) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err_any) begin
          state_d = ST_ACQUIRE;
          good_d  = 8'd0;
        end else if (good_frame) begin
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        good_d  = 8'd0;
      end
    endcase
  end

  // State registers; syncs reset to their idle-high level so reset creates no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      rgb1_q        <= 12'd0;
      line_clks_q   <= 12'd0;
      low_clks_q    <= 12'd0;
      phase_q       <= '0;
      pix_cnt_q     <= 10'd0;
      v_line_q      <= 10'd0;
      vs_lines_q    <= 10'd0;
      state_q       <= ST_UNLOCKED;
      good_q        <= 8'd0;
      frame_bad_q   <= 1'b0;
      frame_count_q <= 16'd0;
      err_count_q   <= 8'd0;
      timing_err_q  <= 1'b0;
      blank_err_q   <= 1'b0;
      probe_valid_q <= 1'b0;
      probe_rgb_q   <= 12'd0;
    end else begin
      hs1_q         <= hs1_d;
      hs2_q         <= hs2_d;
      vs1_q         <= vs1_d;
      vs2_q         <= vs2_d;
      rgb1_q        <= rgb1_d;
      line_clks_q   <= line_clks_d;
      low_clks_q    <= low_clks_d;
      phase_q       <= phase_d;
      pix_cnt_q     <= pix_cnt_d;
      v_line_q      <= v_line_d;
      vs_lines_q    <= vs_lines_d;
      state_q       <= state_d;
      good_q        <= good_d;
      frame_bad_q   <= frame_bad_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      timing_err_q  <= timing_err_d;
      blank_err_q   <= blank_err_d;
      probe_valid_q <= probe_valid_d;
      probe_rgb_q   <= probe_rgb_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign timing_err  = timing_err_q;
  assign blank_err   = blank_err_q;
  assign probe_valid = probe_valid_q;
  assign probe_rgb   = probe_rgb_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a shrunken raster (24x10 pixels, 4 clks/pixel).
// Expected pulses are queued as stimulus is issued; a negedge monitor pops and compares.
// Status (lock, counters) is compared at frame boundaries against hand-derived values.
module tb_vga_frame_monitor;
  localparam int CPP = 4;
  localparam int HA = 16, HT = 24, HS = 3, HB = 2;
  localparam int VA = 6,  VT = 10, VS = 2, VB = 1;
  localparam int XS = HS + HB;
  localparam int YS = VS + VB;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  probe_x, probe_y;
  logic        locked;
  logic [15:0] frame_count;
  logic [7:0]  err_count;
  logic        timing_err, blank_err, probe_valid;
  logic [11:0] probe_rgb;

  vga_frame_monitor_if vif ();

  vga_frame_monitor #(
    .CLKS_PER_PIXEL(CPP), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .vga(vif), .probe_x(probe_x), .probe_y(probe_y),
    .locked(locked), .frame_count(frame_count), .err_count(err_count),
    .timing_err(timing_err), .blank_err(blank_err), .probe_valid(probe_valid),
    .probe_rgb(probe_rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_probe_q[$];
  logic [7:0]  exp_terr_q[$];
  logic        exp_blank_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL unexpected_%s: pulse seen with nothing queued (t=%0t)", name, $time);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_frame_count"}, int'(frame_count), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_timing_err"}, int'(timing_err), 0);
    chk({tag, "_blank_err"}, int'(blank_err), 0);
    chk({tag, "_probe_valid"}, int'(probe_valid), 0);
    chk({tag, "_probe_rgb"}, int'(probe_rgb), 0);
  endtask

  task automatic status(input string tag, input int exp_lock, input int exp_fc, input int exp_err);
    chk({tag, "_locked"}, int'(locked), exp_lock);
    chk({tag, "_frame_count"}, int'(frame_count), exp_fc);
    chk({tag, "_err_count"}, int'(err_count), exp_err);
  endtask

  task automatic drive(input logic hs, input logic vs, input logic [11:0] rgb);
    @(negedge clk);
    vif.hsync = hs;
    vif.vsync = vs;
    vif.vga_r = rgb[11:8];
    vif.vga_g = rgb[7:4];
    vif.vga_b = rgb[3:0];
  endtask

  // One frame starting with hsync and vsync falling together.
  // color lands at active (cx,cy); long_line stretches line 4 by one pixel;
  // blank_hs puts 12'h00F in line 4's hsync pulse; rst_line pulses reset at that line start.
  task automatic send_frame(input logic [11:0] color, input int cx, input int cy,
                            input bit long_line, input bit blank_hs, input int rst_line);
    for (int ln = 0; ln < VT; ln++) begin
      int npix;
      npix = (long_line && ln == 4) ? HT + 1 : HT;
      for (int px = 0; px < npix; px++) begin
        logic [11:0] rgb;
        rgb = 12'd0;
        if (ln - YS == cy && px - XS == cx) rgb = color;
        if (blank_hs && ln == 4 && px < HS) rgb = 12'h00F;
        for (int c = 0; c < CPP; c++) begin
          drive(!(px < HS), !(ln < VS), rgb);
          if (ln == rst_line && px == 0) begin
            if (c == 0) reset = 1'b1;
            if (c == 1) begin
              reset = 1'b0;
              check_zero("in_reset");
            end
            if (c == 2) check_zero("after_reset");
          end
        end
      end
    end
  endtask

  // Scoreboard monitor: every DUT pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (probe_valid) begin
      if (exp_probe_q.size() == 0) unexpected("probe_valid");
      else chk("probe_rgb", int'(probe_rgb), int'(exp_probe_q.pop_front()));
    end
    if (timing_err) begin
      if (exp_terr_q.size() == 0) unexpected("timing_err");
      else chk("err_count_at_timing_err", int'(err_count), int'(exp_terr_q.pop_front()));
    end
    if (blank_err) begin
      if (exp_blank_q.size() == 0) unexpected("blank_err");
      else chk("locked_at_blank_err", int'(locked), int'(exp_blank_q.pop_front()));
    end
  end

  initial begin
    reset     = 1'b1;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.vga_r = 4'd0;
    vif.vga_g = 4'd0;
    vif.vga_b = 4'd0;
    probe_x   = 10'd0;
    probe_y   = 10'd0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (5) drive(1'b1, 1'b1, 12'd0);

    // Clean frames with a red pixel at (0,0); lock at the third vsync edge.
    for (int f = 0; f < 3; f++) begin
      exp_probe_q.push_back(12'hF00);
      send_frame(12'hF00, 0, 0, 1'b0, 1'b0, -1);
    end
    status("lock1", 1, 2, 0);

    // Last active pixel is captured; one past the right edge never fires.
    probe_x = 10'd15;
    probe_y = 10'd5;
    for (int f = 0; f < 2; f++) begin
      exp_probe_q.push_back(12'hABC);
      send_frame(12'hABC, 15, 5, 1'b0, 1'b0, -1);
    end
    probe_x = 10'd16;
    probe_y = 10'd0;
    send_frame(12'h000, -1, -1, 1'b0, 1'b0, -1);
    status("probe_edges", 1, 5, 0);

    // One 25-pixel line while locked, then relock after two clean frames.
    exp_terr_q.push_back(8'd1);
    send_frame(12'h000, -1, -1, 1'b1, 1'b0, -1);
    status("long_line", 0, 6, 1);
    send_frame(12'h000, -1, -1, 1'b0, 1'b0, -1);
    status("relock_a", 0, 6, 1);
    send_frame(12'h000, -1, -1, 1'b0, 1'b0, -1);
    status("relock_b", 0, 7, 1);
    send_frame(12'h000, -1, -1, 1'b0, 1'b0, -1);
    status("relock_c", 1, 8, 1);

    // Colour inside the hsync pulse: three blanking pulses, lock unaffected.
    for (int i = 0; i < HS; i++) exp_blank_q.push_back(1'b1);
    send_frame(12'h000, -1, -1, 1'b0, 1'b1, -1);
    status("blank", 1, 9, 1);

    // Reset mid-frame; the (0,0) capture precedes the reset, the rest is discarded.
    probe_x = 10'd0;
    probe_y = 10'd0;
    exp_probe_q.push_back(12'hF00);
    send_frame(12'hF00, 0, 0, 1'b0, 1'b0, 4);
    status("partial", 0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      exp_probe_q.push_back(12'hF00);
      send_frame(12'hF00, 0, 0, 1'b0, 1'b0, -1);
      if (f == 0) status("post_reset", 0, 0, 0);
    end
    status("lock2", 1, 2, 0);

    // Sync stall: counters saturate silently, first edge afterwards is an error.
    repeat (5000) drive(1'b1, 1'b1, 12'd0);
    status("stall", 1, 2, 0);
    exp_terr_q.push_back(8'd1);
    exp_probe_q.push_back(12'hF00);
    send_frame(12'hF00, 0, 0, 1'b0, 1'b0, -1);
    status("after_stall", 0, 2, 1);

    repeat (50) drive(1'b1, 1'b1, 12'd0);
    chk("probe_left", exp_probe_q.size(), 0);
    chk("timing_err_left", exp_terr_q.size(), 0);
    chk("blank_err_left", exp_blank_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
